// File: rtl/dp_fifo_pkg.sv
// Shared widths and depth helper for the dual-port-memory FIFO controller.
package dp_fifo_pkg;

   localparam int unsigned DP_DATA_W = 16;
   localparam int unsigned DP_ADR_W  = 10;

   function automatic int unsigned depth_of(input int unsigned adr_w);
      return 32'd1 << adr_w;
   endfunction

   localparam int unsigned DEPTH = depth_of(DP_ADR_W);

endpackage

// File: rtl/dp_fifo_ctrl_obuf.sv
// Two-entry output buffer: captures memory read data in order and presents the oldest entry.
module dp_fifo_obuf #(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic [DATA_W-1:0] dat_i,
   input  logic              pop_i,
   output logic [1:0]        cnt_o,
   output logic [DATA_W-1:0] dat_o
);

   logic [DATA_W-1:0] ent_q [2];
   logic              wr_q, wr_d;
   logic              rd_q, rd_d;
   logic [1:0]        cnt_q, cnt_d;

   always_comb begin
      wr_d  = wr_q ^ push_i;
      rd_d  = rd_q ^ pop_i;
      cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) ent_q[i] <= '0;
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (push_i) ent_q[wr_q] <= dat_i;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign dat_o = ent_q[rd_q];

endmodule

// File: rtl/dp_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM with a 1-cycle read latency.
// Optional `level` output enabled by defining DP_FIFO_CTRL_LEVEL_EN.
module dp_fifo_ctrl
   import dp_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DP_DATA_W,
   parameter int unsigned ADR_W  = DP_ADR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_dat,
   output logic              in_ready,
   output logic              mem_wr_en,
   output logic [ADR_W-1:0]  mem_wr_adr,
   output logic [DATA_W-1:0] mem_dat_in,
   output logic [ADR_W-1:0]  mem_rd_adr,
   input  logic [DATA_W-1:0] mem_dat_out,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_dat,
`ifdef DP_FIFO_CTRL_LEVEL_EN
   output logic [ADR_W+1:0]  level,
`endif
   input  logic              out_ready
);

   localparam logic [ADR_W:0] DEPTH_C = (ADR_W+1)'(depth_of(ADR_W));

   logic [ADR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADR_W:0]   mem_cnt_q, mem_cnt_d;
   logic             rd_pend_q;
   logic [1:0]       ob_cnt;
   logic             push, pop, rd_iss;

   assign in_ready = (mem_cnt_q < DEPTH_C);
   assign push     = in_valid & in_ready;
   assign out_valid = (ob_cnt != 2'd0);
   assign pop      = out_valid & out_ready;

   // Issue only if buffer occupancy plus the in-flight read, net of this cycle's pop, leaves room.
   assign rd_iss = (mem_cnt_q != '0) &&
                   (({1'b0, ob_cnt} + {2'b00, rd_pend_q}) < (3'd2 + {2'b00, pop}));

   always_comb begin
      wr_ptr_d  = wr_ptr_q + ADR_W'(push);
      rd_ptr_d  = rd_ptr_q + ADR_W'(rd_iss);
      mem_cnt_d = mem_cnt_q + (ADR_W+1)'(push) - (ADR_W+1)'(rd_iss);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         mem_cnt_q <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         mem_cnt_q <= mem_cnt_d;
         rd_pend_q <= rd_iss;
      end
   end

   assign mem_wr_en  = push;
   assign mem_wr_adr = wr_ptr_q;
   assign mem_dat_in = in_dat;
   assign mem_rd_adr = rd_ptr_q;

   dp_fifo_obuf #(.DATA_W(DATA_W)) u_obuf (
      .clk    (clk),
      .rst_n  (reset),
      .push_i (rd_pend_q),
      .dat_i  (mem_dat_out),
      .pop_i  (pop),
      .cnt_o  (ob_cnt),
      .dat_o  (out_dat)
   );

`ifdef DP_FIFO_CTRL_LEVEL_EN
   logic [ADR_W+1:0] level_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) level_q <= '0;
      else        level_q <= (ADR_W+2)'(mem_cnt_q) + (ADR_W+2)'(rd_pend_q) + (ADR_W+2)'(ob_cnt);
   end

   assign level = level_q;
`endif

endmodule
